// File: rtl/filt_ppi_pkg.sv
// Shared definitions for the polyphase filter path: rotation direction
// constants and the commutator position-index width helper.
package filt_ppi_pkg;

  localparam bit C_DIR_CW  = 1'b0;
  localparam bit C_DIR_CCW = 1'b1;

  // Never narrower than one bit, so a position counter always exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled register bank element with asynchronous active-low clear.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/decommutator.sv
// Serial-to-parallel input commutator: steers consecutive samples into D
// polyphase slots and presents a full frame with a one-cycle strobe.
module decommutator
  import filt_ppi_pkg::*;
#(
  parameter bit gp_ccw               = C_DIR_CCW,
  parameter int gp_idata_width       = 26,
  parameter int gp_decimation_factor = 32
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst_an,
  input  logic                                           i_ena,
  input  logic                                           i_sync,
  input  logic [gp_idata_width-1:0]                      i_data,
  output logic [gp_decimation_factor*gp_idata_width-1:0] o_data,
  output logic                                           o_clk,
  output logic [idx_width(gp_decimation_factor)-1:0]     o_idx
);

  localparam int W  = gp_idata_width;
  localparam int D  = gp_decimation_factor;
  localparam int IW = idx_width(D);
  localparam logic [IW-1:0] LAST_POS = IW'(D - 1);

  logic [IW-1:0] idx_reg;
  logic          strobe_reg;
  logic          accept;
  logic          frame_done;
  logic [W-1:0]  stage_q [D-1];

  assign accept     = i_ena & ~i_sync;
  assign frame_done = accept & (idx_reg == LAST_POS);

  // Staging is indexed by frame position; direction only matters when
  // the output bank picks its slots.
  generate
    for (genvar gi = 0; gi < D - 1; gi++) begin : g_stage
      logic wr;
      if (gi == 0) begin : g_first
        assign wr = i_ena & (i_sync | (idx_reg == '0));
      end else begin : g_rest
        assign wr = accept & (idx_reg == IW'(gi));
      end

      dff #(.WIDTH(W)) u_stage (
        .clk   (i_clk),
        .rst_n (i_rst_an),
        .ena   (wr),
        .d     (i_data),
        .q     (stage_q[gi])
      );
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_out
      localparam int POS = gp_ccw ? gi : (D - 1 - gi);
      logic [W-1:0] slot_d;
      // The last position of the frame comes straight from the input.
      if (POS == D - 1) begin : g_live
        assign slot_d = i_data;
      end else begin : g_staged
        assign slot_d = stage_q[POS];
      end

      dff #(.WIDTH(W)) u_out (
        .clk   (i_clk),
        .rst_n (i_rst_an),
        .ena   (frame_done),
        .d     (slot_d),
        .q     (o_data[gi*W +: W])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      idx_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      strobe_reg <= frame_done;
      if (i_ena) begin
        if (i_sync) begin
          idx_reg <= IW'(1);
        end else if (idx_reg == LAST_POS) begin
          idx_reg <= '0;
        end else begin
          idx_reg <= idx_reg + IW'(1);
        end
      end
    end
  end

  assign o_idx = idx_reg;
  assign o_clk = strobe_reg;

endmodule

// File: tb/tb_decommutator.sv
// Bench for decommutator (D=4, W=8): CCW and CW instances share stimulus and
// are checked against a frame-list reference model after every clock.
module tb_decommutator;

  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_an;
  logic         ena;
  logic         sync;
  logic [W-1:0] data;

  logic [D*W-1:0] data_ccw, data_cw;
  logic           strobe_ccw, strobe_cw;
  logic [1:0]     idx_ccw, idx_cw;

  int checks = 0;
  int errors = 0;

  int          frame[$];
  logic [31:0] exp_ccw = '0;
  logic [31:0] exp_cw  = '0;
  logic        exp_strobe = 1'b0;

  always #5 clk = ~clk;

  decommutator #(.gp_ccw(1'b1), .gp_idata_width(W), .gp_decimation_factor(D)) dut_ccw (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_sync(sync), .i_data(data),
    .o_data(data_ccw), .o_clk(strobe_ccw), .o_idx(idx_ccw)
  );

  decommutator #(.gp_ccw(1'b0), .gp_idata_width(W), .gp_decimation_factor(D)) dut_cw (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_sync(sync), .i_data(data),
    .o_data(data_cw), .o_clk(strobe_cw), .o_idx(idx_cw)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_ccw"}, data_ccw, exp_ccw);
    check({tag, ".data_cw"}, data_cw, exp_cw);
    check({tag, ".clk_ccw"}, 32'(strobe_ccw), 32'(exp_strobe));
    check({tag, ".clk_cw"}, 32'(strobe_cw), 32'(exp_strobe));
    check({tag, ".idx_ccw"}, 32'(idx_ccw), frame.size());
    check({tag, ".idx_cw"}, 32'(idx_cw), frame.size());
  endtask

  // Model: a frame is just the list of samples accepted since the last
  // completion or sync; the first sample goes to slot 0 (CCW) or D-1 (CW).
  task automatic model_edge(input logic e, input logic s, input logic [W-1:0] d);
    exp_strobe = 1'b0;
    if (e) begin
      if (s) begin
        frame.delete();
        frame.push_back(int'(d));
      end else begin
        frame.push_back(int'(d));
        if (frame.size() == D) begin
          exp_ccw = '0;
          exp_cw  = '0;
          for (int i = 0; i < D; i++) begin
            exp_ccw = exp_ccw | (32'(frame[i]) << (W * i));
            exp_cw  = exp_cw  | (32'(frame[i]) << (W * (D - 1 - i)));
          end
          exp_strobe = 1'b1;
          frame.delete();
        end
      end
    end
  endtask

  task automatic model_reset();
    frame.delete();
    exp_ccw = '0;
    exp_cw = '0;
    exp_strobe = 1'b0;
  endtask

  task automatic step(input string tag, input logic e, input logic s, input logic [W-1:0] d);
    ena = e;
    sync = s;
    data = d;
    @(posedge clk);
    model_edge(e, s, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_an = 1'b0;
    ena  = 1'($urandom);
    sync = 1'($urandom);
    data = W'($urandom);
    #12;
    check_all("reset");
    check("reset.const", data_ccw, 32'h0);
    rst_an = 1'b1;

    // CCW / CW frames, then back-to-back frame
    for (int i = 1; i <= 4; i++) step("frame1", 1'b1, 1'b0, W'(i));
    check("frame1.ccw_const", data_ccw, 32'h04030201);
    check("frame1.cw_const", data_cw, 32'h01020304);
    for (int i = 5; i <= 8; i++) step("frame2", 1'b1, 1'b0, W'(i));
    check("frame2.ccw_const", data_ccw, 32'h08070605);
    check("frame2.strobe", 32'(strobe_ccw), 32'd1);

    // Enable gaps with toggling data; strobe must clear during a gap
    step("gaps", 1'b0, 1'b0, W'($urandom));
    step("gaps", 1'b1, 1'b0, 8'h01);
    step("gaps", 1'b0, 1'b0, W'($urandom));
    step("gaps", 1'b1, 1'b0, 8'h02);
    step("gaps", 1'b0, 1'b1, W'($urandom));
    step("gaps", 1'b0, 1'b0, W'($urandom));
    step("gaps", 1'b1, 1'b0, 8'h03);
    step("gaps", 1'b1, 1'b0, 8'h04);
    check("gaps.ccw_const", data_ccw, 32'h04030201);

    // Sync realign at the last position: no strobe, partial frame dropped
    step("sync", 1'b1, 1'b0, 8'h99);
    step("sync", 1'b1, 1'b0, 8'h99);
    step("sync", 1'b1, 1'b0, 8'h99);
    step("sync", 1'b1, 1'b1, 8'h81);
    check("sync.no_strobe", 32'(strobe_ccw), 32'd0);
    step("sync", 1'b1, 1'b0, 8'h82);
    step("sync", 1'b1, 1'b0, 8'h83);
    step("sync", 1'b1, 1'b0, 8'h84);
    check("sync.ccw_const", data_ccw, 32'h84838281);

    // Mid-frame asynchronous reset
    step("midrst", 1'b1, 1'b0, 8'h11);
    step("midrst", 1'b1, 1'b0, 8'h22);
    rst_an = 1'b0;
    #1;
    model_reset();
    check_all("midrst.async");
    #2;
    rst_an = 1'b1;
    for (int i = 5; i <= 8; i++) step("midrst", 1'b1, 1'b0, W'(i));
    check("midrst.ccw_const", data_ccw, 32'h08070605);
    step("midrst", 1'b1, 1'b0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
